result_writer: RTL and testbench
================================

RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 Parameter: W, 18, width of each multiply-accumulate result word.
REQ-002 Parameter: AW, 4, result RAM address width (16 words per frame).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low; sampled on rising clk only.
REQ-005 start  input  1  one-cycle pulse; begins a new frame.
REQ-006 cap_en  input  1  capture strobe from the ALU write-enable (web).
REQ-007 mu1, mu2, mu3, mu4  input  W each  the four column results, valid when cap_en=1.
REQ-008 ram_we  output  1  result RAM write enable.
REQ-009 ram_addr  output  AW  result RAM write address.
REQ-010 ram_wdata  output  W  result RAM write data.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 frame_done  output  1  one-cycle pulse after the 16th word of a frame is written.
REQ-013 overrun  output  1  sticky flag; a capture strobe was dropped.
REQ-014 max_val  output  W  largest word written in the current frame.
REQ-015 max_idx  output  AW  address of max_val.

Function
REQ-016 States IDLE, DRAIN, DONE are the only states; every output is driven from registered state, with no combinational path from any input to any output.
REQ-017 In IDLE, cap_en=1 latches mu1..mu4 into hold[0..3], clears the sub-index to 0, and moves the state to DRAIN on the next edge.
REQ-018 In DRAIN, the block holds ram_we=1, ram_wdata=hold[sub] and ram_addr=wr_ptr, and increments both sub and wr_ptr every cycle.
REQ-019 Latency: cap_en high in cycle N produces writes in cycles N+1..N+4 with data mu1, mu2, mu3, mu4, in that order.
REQ-020 At sub=3, if wr_ptr is not 15, the next state is IDLE; if wr_ptr=15, the next state is DONE and wr_ptr wraps to 0.
REQ-021 frame_done is 1 for exactly the first cycle in DONE.
REQ-022 DONE persists until start or rst; ram_we=0 throughout DONE.
REQ-023 cap_en=1 in DRAIN or DONE sets overrun; the data is dropped, and hold, wr_ptr and sub are unchanged.
REQ-024 Max tracking: on each write, if wdata > max_val (unsigned), max_val and max_idx take wdata and ram_addr on the next edge.
REQ-025 Max tracking on ties: the earlier index is kept.
REQ-026 The first write of a frame always loads max_val and max_idx.
REQ-027 start=1 clears wr_ptr, sub, max_val, max_idx and overrun, forces the state to IDLE, and aborts any drain in progress with no further writes.
REQ-028 start=1 takes priority over cap_en in the same cycle; that capture is ignored and overrun is not set.
REQ-029 ram_addr and ram_wdata hold their last values when ram_we=0; the RAM ignores them.
REQ-030 All arithmetic is unsigned; wr_ptr wraps modulo 16 and nothing saturates.

Reset
REQ-031 rst=0 at a rising edge forces state=IDLE, wr_ptr=0, sub=0 and hold[0..3]=0.
REQ-032 rst=0 at a rising edge forces ram_we=0, ram_addr=0, ram_wdata=0, busy=0, frame_done=0, overrun=0, max_val=0 and max_idx=0.
REQ-033 Reset asserted mid-drain discards the remaining words; the first capture after reset writes to address 0.
REQ-034 rst has priority over start and cap_en.

Verification
REQ-035 Single capture: reset, start, then cap_en with mu=(10,20,30,40) -> writes 10@0, 20@1, 30@2, 40@3 in cycles N+1..N+4; busy=1 for 4 cycles; max_val=40, max_idx=3.
REQ-036 Full frame: 4 captures spaced 8 cycles apart, values 1..16 -> 16 writes to addresses 0..15; frame_done pulses once, the cycle after the address-15 write; state=DONE; max_val=16, max_idx=15.
REQ-037 Overrun: cap_en at N and again at N+2 -> only the first set is written; overrun=1 from N+3 and stays 1 until start.
REQ-038 DONE lockout: cap_en while in DONE -> no write and overrun=1; then start -> overrun=0, and the next capture writes to address 0.
REQ-039 Tie and max: mu=(0x3FFFF,5,0x3FFFF,0) -> max_val=0x3FFFF, max_idx=0.
REQ-040 Reset and start abort: rst=0 at the second drain cycle -> no further ram_we and all outputs 0; repeat with start instead of rst -> the drain stops, and start together with cap_en in one cycle produces no write.

Source files
------------

// File: rtl/result_writer_if.sv
// Bundles the capture inputs, result RAM write port and frame status
// of the result writer into one interface.
interface result_writer_if #(
    parameter int W  = 18,
    parameter int AW = 4
);
    logic          start;
    logic          cap_en;
    logic [W-1:0]  mu1;
    logic [W-1:0]  mu2;
    logic [W-1:0]  mu3;
    logic [W-1:0]  mu4;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_wdata;
    logic          busy;
    logic          frame_done;
    logic          overrun;
    logic [W-1:0]  max_val;
    logic [AW-1:0] max_idx;

    modport master (
        output start, cap_en, mu1, mu2, mu3, mu4,
        input  ram_we, ram_addr, ram_wdata, busy, frame_done, overrun,
               max_val, max_idx
    );

    modport slave (
        input  start, cap_en, mu1, mu2, mu3, mu4,
        output ram_we, ram_addr, ram_wdata, busy, frame_done, overrun,
               max_val, max_idx
    );
endinterface

// File: rtl/result_writer.sv
// Serialises four captured column results into the result RAM, one word
// per cycle, tracking the frame maximum and flagging dropped captures.
module result_writer #(
    parameter int W  = 18,
    parameter int AW = 4
) (
    input  logic            clk,
    input  logic            rst,
    result_writer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    localparam logic [AW-1:0] LAST_ADDR = '1;

    state_t        state;
    logic [W-1:0]  hold [4];
    logic [1:0]    sub;
    logic [AW-1:0] wr_ptr;
    logic          first_wr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            sub            <= '0;
            first_wr       <= 1'b1;
            for (int i = 0; i < 4; i++) hold[i] <= '0;
            bus.ram_we     <= 1'b0;
            bus.ram_addr   <= '0;
            bus.ram_wdata  <= '0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.overrun    <= 1'b0;
            bus.max_val    <= '0;
            bus.max_idx    <= '0;
        end else if (bus.start) begin
            // Abort any drain; ram_addr/ram_wdata keep their last values.
            state          <= IDLE;
            wr_ptr         <= '0;
            sub            <= '0;
            first_wr       <= 1'b1;
            bus.ram_we     <= 1'b0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.overrun    <= 1'b0;
            bus.max_val    <= '0;
            bus.max_idx    <= '0;
        end else begin
            // Strict greater-than keeps the earlier index on ties.
            if (bus.ram_we) begin
                first_wr <= 1'b0;
                if (first_wr || (bus.ram_wdata > bus.max_val)) begin
                    bus.max_val <= bus.ram_wdata;
                    bus.max_idx <= bus.ram_addr;
                end
            end

            bus.frame_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.cap_en) begin
                        hold[0]       <= bus.mu1;
                        hold[1]       <= bus.mu2;
                        hold[2]       <= bus.mu3;
                        hold[3]       <= bus.mu4;
                        sub           <= 2'd0;
                        state         <= DRAIN;
                        bus.busy      <= 1'b1;
                        bus.ram_we    <= 1'b1;
                        bus.ram_wdata <= bus.mu1;
                        bus.ram_addr  <= wr_ptr;
                    end
                end

                DRAIN: begin
                    if (bus.cap_en) bus.overrun <= 1'b1;
                    sub    <= sub + 2'd1;
                    wr_ptr <= wr_ptr + AW'(1);
                    if (sub == 2'd3) begin
                        bus.ram_we <= 1'b0;
                        if (wr_ptr == LAST_ADDR) begin
                            state          <= DONE;
                            bus.frame_done <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end else begin
                        bus.ram_wdata <= hold[sub + 2'd1];
                        bus.ram_addr  <= wr_ptr + AW'(1);
                    end
                end

                DONE: begin
                    if (bus.cap_en) bus.overrun <= 1'b1;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_result_writer.sv
// Directed bench for result_writer: table of single-frame captures plus
// hand-written sequences for frame wrap, overrun, lockout and aborts.
module tb_result_writer;
    localparam int W  = 18;
    localparam int AW = 4;

    logic clk;
    logic rst;
    int   tests;
    int   failed;

    result_writer_if #(.W(W), .AW(AW)) bus ();

    result_writer #(.W(W), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  m1;
        logic [W-1:0]  m2;
        logic [W-1:0]  m3;
        logic [W-1:0]  m4;
        logic [W-1:0]  exp_max;
        logic [AW-1:0] exp_idx;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic c,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] d, input logic [W-1:0] e);
        bus.start  = s;
        bus.cap_en = c;
        bus.mu1    = a;
        bus.mu2    = b;
        bus.mu3    = d;
        bus.mu4    = e;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulseStart();
        applyStimulus(1'b1, 1'b0, '0, '0, '0, '0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    // Capture in the current cycle, return in the first write cycle.
    task automatic capture(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] d, input logic [W-1:0] e);
        applyStimulus(1'b0, 1'b1, a, b, d, e);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic expectWrite(input string name, input int addr,
                               input logic [W-1:0] data);
        checkOutput({name, " we"}, 32'(bus.ram_we), 32'd1);
        checkOutput({name, " addr"}, 32'(bus.ram_addr), 32'(addr));
        checkOutput({name, " data"}, 32'(bus.ram_wdata), 32'(data));
        checkOutput({name, " busy"}, 32'(bus.busy), 32'd1);
        tick();
    endtask

    task automatic expectAllZero(input string name);
        checkOutput({name, " we"}, 32'(bus.ram_we), 32'd0);
        checkOutput({name, " addr"}, 32'(bus.ram_addr), 32'd0);
        checkOutput({name, " data"}, 32'(bus.ram_wdata), 32'd0);
        checkOutput({name, " busy"}, 32'(bus.busy), 32'd0);
        checkOutput({name, " frame_done"}, 32'(bus.frame_done), 32'd0);
        checkOutput({name, " overrun"}, 32'(bus.overrun), 32'd0);
        checkOutput({name, " max_val"}, 32'(bus.max_val), 32'd0);
        checkOutput({name, " max_idx"}, 32'(bus.max_idx), 32'd0);
    endtask

    initial begin
        logic [W-1:0] words [4];
        tests  = 0;
        failed = 0;

        vecs[0] = '{18'd10, 18'd20, 18'd30, 18'd40, 18'd40, 4'd3};
        vecs[1] = '{18'h3FFFF, 18'd5, 18'h3FFFF, 18'd0, 18'h3FFFF, 4'd0};
        vecs[2] = '{18'd7, 18'd7, 18'd7, 18'd7, 18'd7, 4'd0};
        vecs[3] = '{18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 4'd0};
        vecs[4] = '{18'd100, 18'd3, 18'd200, 18'd200, 18'd200, 4'd2};
        vecs[5] = '{18'd5, 18'd1, 18'd2, 18'd3, 18'd5, 4'd0};

        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        tick();
        tick();
        expectAllZero("reset");
        rst = 1'b1;

        // Each vector is a fresh frame: four writes at 0..3, then max check.
        for (int i = 0; i < 6; i++) begin
            pulseStart();
            words[0] = vecs[i].m1;
            words[1] = vecs[i].m2;
            words[2] = vecs[i].m3;
            words[3] = vecs[i].m4;
            capture(words[0], words[1], words[2], words[3]);
            for (int j = 0; j < 4; j++)
                expectWrite($sformatf("vec%0d w%0d", i, j), j, words[j]);
            checkOutput($sformatf("vec%0d idle we", i), 32'(bus.ram_we), 32'd0);
            checkOutput($sformatf("vec%0d idle busy", i), 32'(bus.busy), 32'd0);
            checkOutput($sformatf("vec%0d hold addr", i), 32'(bus.ram_addr), 32'd3);
            checkOutput($sformatf("vec%0d hold data", i), 32'(bus.ram_wdata), 32'(words[3]));
            checkOutput($sformatf("vec%0d max_val", i), 32'(bus.max_val), 32'(vecs[i].exp_max));
            checkOutput($sformatf("vec%0d max_idx", i), 32'(bus.max_idx), 32'(vecs[i].exp_idx));
        end

        // Full frame: captures 8 cycles apart, values 1..16 at addresses 0..15.
        pulseStart();
        for (int k = 0; k < 4; k++) begin
            capture(W'(4*k+1), W'(4*k+2), W'(4*k+3), W'(4*k+4));
            for (int j = 0; j < 4; j++) begin
                checkOutput("frame frame_done low", 32'(bus.frame_done), 32'd0);
                expectWrite($sformatf("frame w%0d", 4*k+j), 4*k+j, W'(4*k+j+1));
            end
            if (k < 3) begin
                checkOutput("frame gap busy", 32'(bus.busy), 32'd0);
                checkOutput("frame gap frame_done", 32'(bus.frame_done), 32'd0);
                tick();
                tick();
                tick();
            end
        end
        checkOutput("frame frame_done", 32'(bus.frame_done), 32'd1);
        checkOutput("frame done we", 32'(bus.ram_we), 32'd0);
        checkOutput("frame done busy", 32'(bus.busy), 32'd1);
        checkOutput("frame max_val", 32'(bus.max_val), 32'd16);
        checkOutput("frame max_idx", 32'(bus.max_idx), 32'd15);
        tick();
        checkOutput("frame frame_done once", 32'(bus.frame_done), 32'd0);
        checkOutput("frame done persists", 32'(bus.busy), 32'd1);

        // DONE lockout: capture is dropped and flagged until start.
        capture(18'd99, 18'd98, 18'd97, 18'd96);
        checkOutput("lockout we", 32'(bus.ram_we), 32'd0);
        checkOutput("lockout overrun", 32'(bus.overrun), 32'd1);
        checkOutput("lockout busy", 32'(bus.busy), 32'd1);
        tick();
        checkOutput("lockout we later", 32'(bus.ram_we), 32'd0);
        pulseStart();
        checkOutput("lockout start overrun", 32'(bus.overrun), 32'd0);
        checkOutput("lockout start busy", 32'(bus.busy), 32'd0);
        capture(18'd11, 18'd22, 18'd33, 18'd44);
        expectWrite("lockout w0", 0, 18'd11);
        expectWrite("lockout w1", 1, 18'd22);
        expectWrite("lockout w2", 2, 18'd33);
        expectWrite("lockout w3", 3, 18'd44);

        // Overrun: second capture two cycles later is dropped.
        pulseStart();
        capture(18'd1, 18'd2, 18'd3, 18'd4);
        expectWrite("ovr w0", 0, 18'd1);
        applyStimulus(1'b0, 1'b1, 18'd9, 18'd9, 18'd9, 18'd9);
        checkOutput("ovr flag before", 32'(bus.overrun), 32'd0);
        expectWrite("ovr w1", 1, 18'd2);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        checkOutput("ovr flag set", 32'(bus.overrun), 32'd1);
        expectWrite("ovr w2", 2, 18'd3);
        expectWrite("ovr w3", 3, 18'd4);
        for (int j = 0; j < 4; j++) begin
            checkOutput("ovr no extra write", 32'(bus.ram_we), 32'd0);
            checkOutput("ovr sticky", 32'(bus.overrun), 32'd1);
            tick();
        end
        pulseStart();
        checkOutput("ovr cleared", 32'(bus.overrun), 32'd0);

        // Reset in the second drain cycle.
        capture(18'd50, 18'd60, 18'd70, 18'd80);
        expectWrite("rstab w0", 0, 18'd50);
        checkOutput("rstab w1 we", 32'(bus.ram_we), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        expectAllZero("rstab");
        for (int j = 0; j < 4; j++) begin
            checkOutput("rstab no write", 32'(bus.ram_we), 32'd0);
            tick();
        end
        capture(18'd1, 18'd2, 18'd3, 18'd4);
        expectWrite("rstab next w0", 0, 18'd1);
        expectWrite("rstab next w1", 1, 18'd2);
        expectWrite("rstab next w2", 2, 18'd3);
        expectWrite("rstab next w3", 3, 18'd4);
        checkOutput("rstab next max_val", 32'(bus.max_val), 32'd4);
        checkOutput("rstab next max_idx", 32'(bus.max_idx), 32'd3);

        // Start with cap_en in the second drain cycle, then again in IDLE.
        capture(18'd5, 18'd6, 18'd7, 18'd8);
        expectWrite("stab w4", 4, 18'd5);
        applyStimulus(1'b1, 1'b1, 18'd77, 18'd77, 18'd77, 18'd77);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        checkOutput("stab we", 32'(bus.ram_we), 32'd0);
        checkOutput("stab busy", 32'(bus.busy), 32'd0);
        checkOutput("stab overrun", 32'(bus.overrun), 32'd0);
        checkOutput("stab max_val", 32'(bus.max_val), 32'd0);
        for (int j = 0; j < 3; j++) begin
            tick();
            checkOutput("stab no write", 32'(bus.ram_we), 32'd0);
        end
        applyStimulus(1'b1, 1'b1, 18'd55, 18'd55, 18'd55, 18'd55);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        checkOutput("stab idle we", 32'(bus.ram_we), 32'd0);
        checkOutput("stab idle busy", 32'(bus.busy), 32'd0);
        tick();
        checkOutput("stab idle we later", 32'(bus.ram_we), 32'd0);
        capture(18'd12, 18'd13, 18'd14, 18'd15);
        expectWrite("stab next w0", 0, 18'd12);
        expectWrite("stab next w1", 1, 18'd13);
        expectWrite("stab next w2", 2, 18'd14);
        expectWrite("stab next w3", 3, 18'd15);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
